// File: rtl/butterfly_sprite_fetch.sv
// Butterfly sprite fetch: maps the beam onto the sprite box, addresses the index ROM, qualifies the palette index.
// Latency: 3 cycles from draw_x/draw_y to idx/idx_valid (rom_addr after 1, rom_q after 2).
// Backpressure: none; one pixel per cycle, the pipeline advances every clock.
//
// Ports:
//   clk, rst_n              pixel clock, asynchronous active-low reset
//   draw_x, draw_y          beam coordinate; pix_valid marks active video
//   frame_start             one-cycle pulse at start of vertical blank
//   pos_x_in/pos_y_in/pos_we  pending sprite top-left write
//   mirror_x                horizontal mirror request (only with BUTTERFLY_MIRROR_EN)
//   rom_addr, rom_q         synchronous sprite index ROM (data one cycle after address)
//   idx, idx_valid          palette index and inside-box/opaque qualifier
//   frame_idx               current animation frame
//
// Build option: define BUTTERFLY_MIRROR_EN to add the mirror_x input and mirrored addressing.

module butterfly_sprite_fetch #(
   parameter int         SPR_W           = 32,
   parameter int         SPR_H           = 32,
   parameter int         FRAMES          = 4,
   parameter int         FRAME_TICKS     = 8,
   parameter int         ADDR_W          = 12,
   parameter logic [3:0] TRANSPARENT_IDX = 4'h5,
   localparam int        FW              = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [9:0]        draw_x,
   input  logic [9:0]        draw_y,
   input  logic              pix_valid,
   input  logic              frame_start,
   input  logic [9:0]        pos_x_in,
   input  logic [9:0]        pos_y_in,
`ifdef BUTTERFLY_MIRROR_EN
   input  logic              mirror_x,
`endif
   input  logic              pos_we,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [3:0]        rom_q,
   output logic [3:0]        idx,
   output logic              idx_valid,
   output logic [FW-1:0]     frame_idx
);

   localparam int LW = $clog2(SPR_W);
   localparam int TW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;

   localparam logic [10:0]       SPR_W_C  = 11'(SPR_W);
   localparam logic [10:0]       SPR_H_C  = 11'(SPR_H);
   localparam logic [ADDR_W-1:0] FRAME_SZ = ADDR_W'(SPR_W * SPR_H);
   localparam logic [TW-1:0]     TICK_MAX = TW'(FRAME_TICKS - 1);
   localparam logic [FW-1:0]     FRAME_MAX = FW'(FRAMES - 1);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [9:0]        pend_x_q, pend_x_d;
   logic [9:0]        pend_y_q, pend_y_d;
   logic [9:0]        act_x_q,  act_x_d;
   logic [9:0]        act_y_q,  act_y_d;
   logic [TW-1:0]     tick_q,   tick_d;
   logic [FW-1:0]     frame_q,  frame_d;
   // Base address of the current frame, advanced alongside frame_q so the
   // frame offset never needs a multiply even when SPR_H is not a power of two.
   logic [ADDR_W-1:0] base_q,   base_d;
   logic [ADDR_W-1:0] addr_q,   addr_d;
   logic              inbox_a_q, inbox_a_d;
   logic              inbox_b_q;
   logic [3:0]        idx_q,    idx_d;
   logic              vld_q,    vld_d;

`ifdef BUTTERFLY_MIRROR_EN
   logic              pend_mir_q, pend_mir_d;
   logic              act_mir_q,  act_mir_d;
`endif

   // ------------------------------------------------------------------
   // Position double-buffer and animation counters
   // ------------------------------------------------------------------
   always_comb begin
      pend_x_d = pend_x_q;
      pend_y_d = pend_y_q;
      act_x_d  = act_x_q;
      act_y_d  = act_y_q;
      tick_d   = tick_q;
      frame_d  = frame_q;
      base_d   = base_q;

      if (pos_we) begin
         pend_x_d = pos_x_in;
         pend_y_d = pos_y_in;
      end

      if (frame_start) begin
         // pend_*_d already carries a same-cycle write, giving the bypass.
         act_x_d = pend_x_d;
         act_y_d = pend_y_d;
         if (tick_q == TICK_MAX) begin
            tick_d = '0;
            if (frame_q == FRAME_MAX) begin
               frame_d = '0;
               base_d  = '0;
            end else begin
               frame_d = frame_q + FW'(1);
               base_d  = base_q + FRAME_SZ;
            end
         end else begin
            tick_d = tick_q + TW'(1);
         end
      end
   end

`ifdef BUTTERFLY_MIRROR_EN
   always_comb begin
      pend_mir_d = pos_we ? mirror_x : pend_mir_q;
      act_mir_d  = frame_start ? pend_mir_d : act_mir_q;
   end
`endif

   // ------------------------------------------------------------------
   // Stage A: box test and ROM address
   // ------------------------------------------------------------------
   logic [10:0]   dx, dy;
   logic          in_box;
   logic [LW-1:0] col;

   // 11-bit differences: bit 10 set means the beam is left of / above the
   // sprite, and a sprite hanging off the right edge cannot wrap into range.
   assign dx = {1'b0, draw_x} - {1'b0, act_x_q};
   assign dy = {1'b0, draw_y} - {1'b0, act_y_q};

   assign in_box = pix_valid
                 && !dx[10] && (dx < SPR_W_C)
                 && !dy[10] && (dy < SPR_H_C);

`ifdef BUTTERFLY_MIRROR_EN
   // SPR_W is a power of two, so SPR_W-1-dx is the bitwise inverse of dx.
   assign col = act_mir_q ? ~dx[LW-1:0] : dx[LW-1:0];
`else
   assign col = dx[LW-1:0];
`endif

   always_comb begin
      addr_d    = addr_q;
      inbox_a_d = in_box;
      if (in_box) begin
         addr_d = base_q + (ADDR_W'(dy) << LW) + ADDR_W'(col);
      end
   end

   // ------------------------------------------------------------------
   // Stage C: transparency qualification on ROM data
   // ------------------------------------------------------------------
   always_comb begin
      vld_d = inbox_b_q && (rom_q != TRANSPARENT_IDX);
      idx_d = vld_d ? rom_q : 4'h0;
   end

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_x_q  <= '0;
         pend_y_q  <= '0;
         act_x_q   <= '0;
         act_y_q   <= '0;
         tick_q    <= '0;
         frame_q   <= '0;
         base_q    <= '0;
         addr_q    <= '0;
         inbox_a_q <= 1'b0;
         inbox_b_q <= 1'b0;
         idx_q     <= 4'h0;
         vld_q     <= 1'b0;
      end else begin
         pend_x_q  <= pend_x_d;
         pend_y_q  <= pend_y_d;
         act_x_q   <= act_x_d;
         act_y_q   <= act_y_d;
         tick_q    <= tick_d;
         frame_q   <= frame_d;
         base_q    <= base_d;
         addr_q    <= addr_d;
         inbox_a_q <= inbox_a_d;
         // Stage B: delay the box flag so it lines up with rom_q.
         inbox_b_q <= inbox_a_q;
         idx_q     <= idx_d;
         vld_q     <= vld_d;
      end
   end

`ifdef BUTTERFLY_MIRROR_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_mir_q <= 1'b0;
         act_mir_q  <= 1'b0;
      end else begin
         pend_mir_q <= pend_mir_d;
         act_mir_q  <= act_mir_d;
      end
   end
`endif

   assign rom_addr  = addr_q;
   assign idx       = idx_q;
   assign idx_valid = vld_q;
   assign frame_idx = frame_q;

endmodule
